hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the 2-stage EX-operand forwarding logic in the 32-bit MIPS pipeline.
- Resolves operand sources over NUM_FWD_STAGES younger-to-older write-back stages.
- Detects load-use hazards and tracks one multi-cycle mult/div unit with a scoreboard FSM.
- Sits beside the ID/EX register. Drives the EX operand muxes, PC/IF-ID hold and ID/EX bubble insertion.

Parameters:
- REG_ADDR_W, 5: register address width.
- NUM_FWD_STAGES, 2: number of forwarding sources. Index 0 is nearest (EX/MEM), index 1 is MEM/WB, and so on.
- MD_LATENCY, 4: mult/div execute cycles from accepted start to done pulse. Must be at least 1.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ex_rs  in  REG_ADDR_W  ID/EX rs
- ex_rt  in  REG_ADDR_W  ID/EX rt
- fwd_reg_write  in  NUM_FWD_STAGES  per-stage write enable
- fwd_write_addr  in  NUM_FWD_STAGES*REG_ADDR_W  per-stage destination; slice i belongs to stage i
- id_rs  in  REG_ADDR_W  IF/ID rs
- id_rt  in  REG_ADDR_W  IF/ID rt
- id_uses_rs  in  1  decode reads rs
- id_uses_rt  in  1  decode reads rt
- id_is_md  in  1  decode instruction is mult/div
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_write_addr  in  REG_ADDR_W  ID/EX destination
- md_start  in  1  mult/div issued from EX this cycle
- md_dest  in  REG_ADDR_W  mult/div destination
- forward_a  out  FWD_SEL_W  rs source select
- forward_b  out  FWD_SEL_W  rt source select
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX controls
- md_busy  out  1  scoreboard occupied
- md_done  out  1  one-cycle result-valid pulse
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Forwarding is combinational.
  - FWD_SEL_W = $clog2(NUM_FWD_STAGES+1).
  - forward_a = i+1 for the lowest i with fwd_reg_write[i] set, slice i nonzero, and slice i equal to ex_rs. Otherwise forward_a = 0 (register file).
  - forward_b uses the same rule against ex_rt.
  - Nearest stage wins.
  - Address 0 never forwards.
- Load-use hazard is combinational. It is true when all of the following hold:
  - ex_mem_read is set;
  - ex_write_addr is nonzero;
  - either (id_uses_rs and id_rs equals ex_write_addr) or (id_uses_rt and id_rt equals ex_write_addr).
- Scoreboard FSM states: IDLE, BUSY, DONE. Registers: state, count (width $clog2(MD_LATENCY+1)), sb_dest.
  - IDLE: on md_start, latch md_dest, set count to MD_LATENCY-1, go to BUSY. If MD_LATENCY=1, go directly to DONE.
  - BUSY: decrement count. When count is 0, go to DONE.
  - DONE: md_done=1 for exactly this cycle. If md_start is set, accept the new op (back-to-back, sb_dest replaced) and go to BUSY. Otherwise go to IDLE.
  - md_start in BUSY is a protocol violation. It is ignored and causes no state change.
  - md_busy=1 in BUSY and DONE.
- md hazard is true when md_busy is set and either:
  - sb_dest is nonzero and a used id_rs/id_rt equals sb_dest; or
  - id_is_md is set and state is BUSY.
  - In DONE the dependence hazard still holds. Release is the cycle after md_done.
- stall = bubble = load-use hazard OR md hazard.
- stall_count: registered. Increments by 1 on each cycle stall is high. Saturates at all-ones.
- Reset values: state=IDLE, count=0, sb_dest=0, md_busy=0, md_done=0, stall_count=0. forward_a/forward_b follow their inputs.
- Reset mid-operation abandons the op. No md_done is produced.
- Reset has priority over md_start in the same cycle.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state encoding;
  - FWD_SEL_W as a function of NUM_FWD_STAGES;
  - forwarding-select constant FWD_REGFILE=0.
- One natural sub-module, fwd_select: a parametrised priority matcher for one operand, instantiated twice (rs, rt).

Test Plan:
- EX/MEM and MEM/WB both write $8, reg_write=1, ex_rs=8 -> forward_a=1. With EX/MEM reg_write=0 -> forward_a=2.
- fwd_write_addr slice0=0 with reg_write=1, ex_rt=0 -> forward_b=0. NUM_FWD_STAGES=3, only stage 2 matches -> select 3.
- ex_mem_read=1, ex_write_addr=9, id_rt=9, id_uses_rt=1 -> stall=bubble=1 for one cycle, stall_count=1. Same case with id_uses_rt=0 -> no stall.
- MD_LATENCY=4, md_start with md_dest=12 at cycle 0 -> md_busy cycles 1-4, md_done only at cycle 4. Decode reading $12 stalls cycles 1-4 and releases at cycle 5.
- md_start in DONE -> md_done pulse, md_busy stays high, new sb_dest latched, next md_done 4 cycles later. id_is_md during BUSY -> stall.
- reset asserted during BUSY -> next cycle md_busy=0, stall=0, no md_done; stall_count cleared. Forced saturation holds at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard states and forwarding-select constants
package hazard_pkg;
  typedef enum logic [1:0] {SB_IDLE, SB_BUSY, SB_DONE} sb_state_t;
  localparam int FWD_REGFILE = 0;
  function automatic int fwd_sel_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select: priority match of one EX operand against the write-back stages
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_FWD_STAGES = 2
) (
  input  logic [REG_ADDR_W-1:0]                i_addr,
  input  logic [NUM_FWD_STAGES-1:0]            i_reg_write,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] i_write_addr,
  output logic [fwd_sel_w(NUM_FWD_STAGES)-1:0] o_sel
);
  localparam int SEL_W = fwd_sel_w(NUM_FWD_STAGES);
  // scan oldest to youngest so the nearest match overwrites
  always_comb begin
    o_sel = SEL_W'(FWD_REGFILE);
    for (int i = NUM_FWD_STAGES - 1; i >= 0; i--)
      if (i_reg_write[i] && |i_write_addr[i*REG_ADDR_W +: REG_ADDR_W] &&
          i_write_addr[i*REG_ADDR_W +: REG_ADDR_W] == i_addr)
        o_sel = SEL_W'(i + 1);
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX forwarding, load-use and mult/div scoreboard stall control
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MD_LATENCY     = 4,
  parameter int CNT_W          = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [REG_ADDR_W-1:0]                ex_rs,
  input  logic [REG_ADDR_W-1:0]                ex_rt,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_reg_write,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_write_addr,
  input  logic [REG_ADDR_W-1:0]                id_rs,
  input  logic [REG_ADDR_W-1:0]                id_rt,
  input  logic                                 id_uses_rs,
  input  logic                                 id_uses_rt,
  input  logic                                 id_is_md,
  input  logic                                 ex_mem_read,
  input  logic [REG_ADDR_W-1:0]                ex_write_addr,
  input  logic                                 md_start,
  input  logic [REG_ADDR_W-1:0]                md_dest,
  output logic [fwd_sel_w(NUM_FWD_STAGES)-1:0] forward_a,
  output logic [fwd_sel_w(NUM_FWD_STAGES)-1:0] forward_b,
  output logic                                 stall,
  output logic                                 bubble,
  output logic                                 md_busy,
  output logic                                 md_done,
  output logic [CNT_W-1:0]                     stall_count
);
  localparam int CW = $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LATENCY - 1);
  sb_state_t r_state, w_state;
  logic [CW-1:0] r_count, w_count;
  logic [REG_ADDR_W-1:0] r_sb_dest, w_sb_dest;
  logic [CNT_W-1:0] r_stall_count;
  logic w_accept, w_load_use, w_dep, w_md_hz, w_hazard;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD_STAGES(NUM_FWD_STAGES)) u_fwd_a (
    .i_addr(ex_rs), .i_reg_write(fwd_reg_write), .i_write_addr(fwd_write_addr), .o_sel(forward_a)
  );
  fwd_select #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD_STAGES(NUM_FWD_STAGES)) u_fwd_b (
    .i_addr(ex_rt), .i_reg_write(fwd_reg_write), .i_write_addr(fwd_write_addr), .o_sel(forward_b)
  );

  always_ff @(posedge clk)
    if (reset) begin
      r_state       <= SB_IDLE;
      r_count       <= '0;
      r_sb_dest     <= '0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state;
      r_count       <= w_count;
      r_sb_dest     <= w_sb_dest;
      r_stall_count <= r_stall_count + CNT_W'(w_hazard && ~&r_stall_count);
    end

  // a start while BUSY is dropped; DONE may accept the next op back-to-back
  always_comb begin
    w_accept  = md_start && r_state != SB_BUSY;
    w_state   = r_state;
    w_count   = r_count;
    w_sb_dest = r_sb_dest;
    if (w_accept) begin
      w_state   = MD_LATENCY == 1 ? SB_DONE : SB_BUSY;
      w_count   = CNT_INIT;
      w_sb_dest = md_dest;
    end else if (r_state == SB_BUSY) begin
      w_count = r_count - 1'b1;
      w_state = r_count <= CW'(1) ? SB_DONE : SB_BUSY;
    end else if (r_state == SB_DONE)
      w_state = SB_IDLE;
  end

  assign md_busy     = r_state != SB_IDLE;
  assign md_done     = r_state == SB_DONE;
  assign w_load_use  = ex_mem_read && |ex_write_addr &&
                       ((id_uses_rs && id_rs == ex_write_addr) || (id_uses_rt && id_rt == ex_write_addr));
  assign w_dep       = |r_sb_dest &&
                       ((id_uses_rs && id_rs == r_sb_dest) || (id_uses_rt && id_rt == r_sb_dest));
  assign w_md_hz     = md_busy && (w_dep || (id_is_md && r_state == SB_BUSY));
  assign w_hazard    = w_load_use || w_md_hz;
  assign stall       = w_hazard;
  assign bubble      = w_hazard;
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard-driven checks of forwarding, stalls and the mult/div tracker
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_uses_rs, id_uses_rt, id_is_md, ex_mem_read, md_start;
  logic [4:0] ex_rs, ex_rt, id_rs, id_rt, ex_write_addr, md_dest;
  logic [1:0] fwd_reg_write;
  logic [9:0] fwd_write_addr;
  logic [2:0] fwd_reg_write3;
  logic [14:0] fwd_write_addr3;
  logic [1:0] fa, fb, fa3, fb3;
  logic stall, bubble, busy, done, stall3, bubble3, busy3, done3;
  logic [31:0] cnt;
  logic [2:0] cnt3;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  typedef struct packed {logic [1:0] rw; logic [4:0] wa0, wa1, rs, rt; logic [1:0] ea, eb;} fcase_t;
  typedef struct packed {logic mr; logic [4:0] wa, rs; logic urs; logic [4:0] rt; logic urt, es;} lcase_t;
  typedef struct packed {logic st; logic [4:0] dst, rs; logic urs, md; logic [2:0] e0, e1;} mcase_t;

  localparam fcase_t FC [6] = '{
    {2'b11, 5'd8, 5'd8, 5'd8, 5'd3, 2'd1, 2'd0},
    {2'b10, 5'd8, 5'd8, 5'd8, 5'd3, 2'd2, 2'd0},
    {2'b01, 5'd0, 5'd4, 5'd0, 5'd0, 2'd0, 2'd0},
    {2'b11, 5'd5, 5'd7, 5'd7, 5'd5, 2'd2, 2'd1},
    {2'b00, 5'd5, 5'd7, 5'd7, 5'd5, 2'd0, 2'd0},
    {2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0}
  };
  localparam lcase_t LC [6] = '{
    {1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1},
    {1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0},
    {1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0},
    {1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0},
    {1'b1, 5'd9, 5'd9, 1'b1, 5'd3, 1'b1, 1'b1},
    {1'b1, 5'd9, 5'd9, 1'b0, 5'd3, 1'b1, 1'b0}
  };
  localparam mcase_t ML [6] = '{
    {1'b1, 5'd12, 5'd12, 1'b1, 1'b0, 3'b000, 3'b000},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b0, 3'b101, 3'b111},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b0, 3'b101, 3'b000},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b0, 3'b101, 3'b000},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b0, 3'b111, 3'b000},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b0, 3'b000, 3'b000}
  };
  localparam mcase_t MB [10] = '{
    {1'b1, 5'd12, 5'd0,  1'b0, 1'b0, 3'b000, 3'b000},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b0, 3'b101, 3'b000},
    {1'b1, 5'd20, 5'd12, 1'b1, 1'b0, 3'b101, 3'b000},
    {1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 3'b100, 3'b000},
    {1'b1, 5'd13, 5'd12, 1'b1, 1'b0, 3'b111, 3'b000},
    {1'b0, 5'd0,  5'd12, 1'b1, 1'b1, 3'b101, 3'b000},
    {1'b0, 5'd0,  5'd13, 1'b1, 1'b0, 3'b101, 3'b000},
    {1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 3'b100, 3'b000},
    {1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 3'b110, 3'b000},
    {1'b0, 5'd0,  5'd13, 1'b1, 1'b0, 3'b000, 3'b000}
  };

  hazard_forward_unit dut (
    .clk(clk), .reset(reset), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .fwd_reg_write(fwd_reg_write), .fwd_write_addr(fwd_write_addr),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_md(id_is_md), .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
    .md_start(md_start), .md_dest(md_dest), .forward_a(fa), .forward_b(fb),
    .stall(stall), .bubble(bubble), .md_busy(busy), .md_done(done), .stall_count(cnt)
  );

  hazard_forward_unit #(.NUM_FWD_STAGES(3), .MD_LATENCY(1), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .fwd_reg_write(fwd_reg_write3), .fwd_write_addr(fwd_write_addr3),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_md(id_is_md), .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
    .md_start(md_start), .md_dest(md_dest), .forward_a(fa3), .forward_b(fb3),
    .stall(stall3), .bubble(bubble3), .md_busy(busy3), .md_done(done3), .stall_count(cnt3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {ex_rs, ex_rt, id_rs, id_rt, ex_write_addr, md_dest} = '0;
    {id_uses_rs, id_uses_rt, id_is_md, ex_mem_read, md_start} = '0;
    fwd_reg_write = '0; fwd_write_addr = '0; fwd_reg_write3 = '0; fwd_write_addr3 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    md_start = 1'b1;
    md_dest = 5'd6;
    step();
    sb.push_back(32'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_total++; if ({busy, done, stall} !== e[2:0]) $display("FAIL reset_flags: got %b want %b", {busy, done, stall}, e[2:0]); else n_pass++;
    n_total++; if (cnt !== e) $display("FAIL reset_count: got %0d want %0d", cnt, e); else n_pass++;
    n_total++; if (cnt3 !== e[2:0]) $display("FAIL reset_count3: got %0d want %0d", cnt3, e[2:0]); else n_pass++;
    step();
    reset = 1'b0;
    md_start = 1'b0;
    step();
    sb.push_back(32'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_total++; if ({busy, done} !== e[1:0]) $display("FAIL reset_beats_start: got %b want %b", {busy, done}, e[1:0]); else n_pass++;
    step();
  endtask

  task automatic test_forward();
    for (int i = 0; i < 6; i++) begin
      fwd_reg_write = FC[i].rw;
      fwd_write_addr = {FC[i].wa1, FC[i].wa0};
      ex_rs = FC[i].rs;
      ex_rt = FC[i].rt;
      sb.push_back({30'd0, FC[i].ea});
      sb.push_back({30'd0, FC[i].eb});
      #1;
      e = sb.pop_front();
      n_total++; if (fa !== e[1:0]) $display("FAIL fwd_a case %0d: got %0d want %0d", i, fa, e[1:0]); else n_pass++;
      e = sb.pop_front();
      n_total++; if (fb !== e[1:0]) $display("FAIL fwd_b case %0d: got %0d want %0d", i, fb, e[1:0]); else n_pass++;
    end
    idle_inputs();
    fwd_reg_write3 = 3'b100;
    fwd_write_addr3 = {5'd9, 5'd9, 5'd9};
    ex_rs = 5'd9;
    ex_rt = 5'd9;
    sb.push_back(32'd3);
    #1;
    e = sb.pop_front();
    n_total++; if (fa3 !== e[1:0]) $display("FAIL fwd3_far: got %0d want %0d", fa3, e[1:0]); else n_pass++;
    fwd_reg_write3 = 3'b110;
    fwd_write_addr3 = {5'd9, 5'd9, 5'd2};
    ex_rt = 5'd2;
    sb.push_back(32'd2);
    sb.push_back(32'd0);
    #1;
    e = sb.pop_front();
    n_total++; if (fa3 !== e[1:0]) $display("FAIL fwd3_mid: got %0d want %0d", fa3, e[1:0]); else n_pass++;
    e = sb.pop_front();
    n_total++; if (fb3 !== e[1:0]) $display("FAIL fwd3_nowrite: got %0d want %0d", fb3, e[1:0]); else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    int exp_cnt;
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      ex_mem_read = LC[i].mr;
      ex_write_addr = LC[i].wa;
      id_rs = LC[i].rs;
      id_uses_rs = LC[i].urs;
      id_rt = LC[i].rt;
      id_uses_rt = LC[i].urt;
      sb.push_back({30'd0, LC[i].es, LC[i].es});
      sb.push_back(exp_cnt);
      @(negedge clk);
      e = sb.pop_front();
      n_total++; if ({stall, bubble} !== e[1:0]) $display("FAIL load_use case %0d: got %b want %b", i, {stall, bubble}, e[1:0]); else n_pass++;
      e = sb.pop_front();
      n_total++; if (cnt !== e) $display("FAIL load_use_count case %0d: got %0d want %0d", i, cnt, e); else n_pass++;
      exp_cnt += LC[i].es;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_md_latency();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      md_start = ML[i].st;
      md_dest = ML[i].dst;
      id_rs = ML[i].rs;
      id_uses_rs = ML[i].urs;
      id_is_md = ML[i].md;
      sb.push_back({26'd0, ML[i].e0, ML[i].e1});
      @(negedge clk);
      e = sb.pop_front();
      n_total++; if ({busy, done, stall} !== e[5:3]) $display("FAIL md_lat4 cycle %0d: got %b want %b", i, {busy, done, stall}, e[5:3]); else n_pass++;
      n_total++; if ({busy3, done3, stall3} !== e[2:0]) $display("FAIL md_lat1 cycle %0d: got %b want %b", i, {busy3, done3, stall3}, e[2:0]); else n_pass++;
      if (i < 5) step();
    end
    sb.push_back(32'd4);
    e = sb.pop_front();
    n_total++; if (cnt !== e) $display("FAIL md_lat4_count: got %0d want %0d", cnt, e); else n_pass++;
    n_total++; if (cnt3 !== 3'd1) $display("FAIL md_lat1_count: got %0d want 1", cnt3); else n_pass++;
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      md_start = MB[i].st;
      md_dest = MB[i].dst;
      id_rs = MB[i].rs;
      id_uses_rs = MB[i].urs;
      id_is_md = MB[i].md;
      sb.push_back({29'd0, MB[i].e0});
      @(negedge clk);
      e = sb.pop_front();
      n_total++; if ({busy, done, stall} !== e[2:0]) $display("FAIL b2b cycle %0d: got %b want %b", i, {busy, done, stall}, e[2:0]); else n_pass++;
      step();
    end
    sb.push_back(32'd5);
    @(negedge clk);
    e = sb.pop_front();
    n_total++; if (cnt !== e) $display("FAIL b2b_count: got %0d want %0d", cnt, e); else n_pass++;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    md_start = 1'b1;
    md_dest = 5'd12;
    id_rs = 5'd12;
    id_uses_rs = 1'b1;
    step();
    md_start = 1'b0;
    sb.push_back(32'b101);
    @(negedge clk);
    e = sb.pop_front();
    n_total++; if ({busy, done, stall} !== e[2:0]) $display("FAIL mid_busy: got %b want %b", {busy, done, stall}, e[2:0]); else n_pass++;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(32'd0);
      @(negedge clk);
      e = sb.pop_front();
      n_total++; if ({busy, done, stall} !== e[2:0]) $display("FAIL mid_abandon cycle %0d: got %b want %b", i, {busy, done, stall}, e[2:0]); else n_pass++;
      if (i == 0) begin
        n_total++; if (cnt !== e) $display("FAIL mid_count_clear: got %0d want %0d", cnt, e); else n_pass++;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    ex_mem_read = 1'b1;
    ex_write_addr = 5'd9;
    id_rt = 5'd9;
    id_uses_rt = 1'b1;
    for (int i = 0; i < 7; i++) step();
    sb.push_back(32'd7);
    @(negedge clk);
    e = sb.pop_front();
    n_total++; if (cnt3 !== e[2:0]) $display("FAIL sat_reach: got %0d want %0d", cnt3, e[2:0]); else n_pass++;
    n_total++; if (bubble3 !== 1'b1) $display("FAIL sat_bubble: got %b want 1", bubble3); else n_pass++;
    for (int i = 0; i < 3; i++) step();
    sb.push_back(32'd7);
    sb.push_back(32'd10);
    @(negedge clk);
    e = sb.pop_front();
    n_total++; if (cnt3 !== e[2:0]) $display("FAIL sat_hold: got %0d want %0d", cnt3, e[2:0]); else n_pass++;
    e = sb.pop_front();
    n_total++; if (cnt !== e) $display("FAIL wide_count: got %0d want %0d", cnt, e); else n_pass++;
    step();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_forward();
    test_load_use();
    test_md_latency();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
